dsa_pix_loader: RTL

DSA_PIX_LOADER -- requirements
Module: dsa_pix_loader

---
 rtl/dsa_pix_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dsa_pix_loader.sv
// Streams 8-bit pixels into 32-bit little-endian words and writes them to an
// accelerator host bus: IN_ADDR setup, IN_DATA words, partial flush, optional start.
module dsa_pix_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_PIXELS = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [15:0]           cfg_npix,
  input  logic                  cfg_auto_start,
  input  logic                  s_pix_valid,
  input  logic [7:0]            s_pix_data,
  input  logic                  s_pix_last,
  output logic                  s_pix_ready,
  output logic                  h_wr_en,
  output logic [ADDR_WIDTH-1:0] h_addr,
  output logic [31:0]           h_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len,
  output logic [15:0]           words_wr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(32'h0000);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_ADDR = ADDR_WIDTH'(32'h0020);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_DATA = ADDR_WIDTH'(32'h0021);
  localparam logic [15:0]           NPIX_MAX     = 16'(MAX_PIXELS);

  typedef enum logic [2:0] {IDLE, SET_ADDR, PACK, FLUSH, START, DONE} state_t;

  state_t                  state, state_n;
  logic [15:0]             npix;
  logic [15:0]             cnt;
  logic [31:0]             word;
  logic                    auto_q;

  logic                    accept;
  logic [1:0]              bpos;
  logic [15:0]             cnt_inc;
  logic [31:0]             word_n;
  logic                    frame_end;
  logic                    cfg_take;
  logic                    npix_clamp;
  logic                    wr_req;
  logic                    data_wr;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [31:0]             wr_data;

  assign s_pix_ready = (state == PACK) && (cnt < npix);
  assign accept      = s_pix_ready && s_pix_valid;
  assign bpos        = cnt[1:0];
  assign cnt_inc     = cnt + 16'd1;
  // A fresh word starts at byte 0 so unused upper bytes of a flushed word stay zero.
  assign word_n      = ((bpos == 2'd0) ? 32'h0 : word) | ({24'h0, s_pix_data} << {bpos, 3'b000});
  assign frame_end   = accept && (s_pix_last || (cnt_inc == npix));
  assign cfg_take    = cfg_valid && ((state == IDLE) || (state == DONE));
  assign npix_clamp  = cfg_npix > NPIX_MAX;

  always_comb begin
    state_n = state;
    wr_req  = 1'b0;
    data_wr = 1'b0;
    wr_addr = ADDR_IN_DATA;
    wr_data = word_n;
    case (state)
      IDLE, DONE: begin
        if (cfg_valid) state_n = (cfg_npix == 16'd0) ? DONE : SET_ADDR;
      end
      SET_ADDR: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_IN_ADDR;
        wr_data = 32'h0;
        state_n = PACK;
      end
      PACK: begin
        if (accept && (bpos == 2'd3)) begin
          wr_req  = 1'b1;
          data_wr = 1'b1;
        end
        if (frame_end) begin
          if (bpos != 2'd3) state_n = FLUSH;
          else              state_n = auto_q ? START : DONE;
        end
      end
      FLUSH: begin
        wr_req  = 1'b1;
        data_wr = 1'b1;
        wr_data = word;
        state_n = auto_q ? START : DONE;
      end
      START: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_CTRL;
        wr_data = 32'h1;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      npix     <= 16'd0;
      cnt      <= 16'd0;
      word     <= 32'h0;
      auto_q   <= 1'b0;
      h_wr_en  <= 1'b0;
      h_addr   <= '0;
      h_wdata  <= 32'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_len  <= 1'b0;
      words_wr <= 16'd0;
    end else begin
      state   <= state_n;
      h_wr_en <= wr_req;
      if (wr_req) begin
        h_addr  <= wr_addr;
        h_wdata <= wr_data;
      end
      if (data_wr) words_wr <= words_wr + 16'd1;

      if (cfg_take) begin
        npix     <= npix_clamp ? NPIX_MAX : cfg_npix;
        auto_q   <= cfg_auto_start;
        err_len  <= npix_clamp;
        cnt      <= 16'd0;
        word     <= 32'h0;
        words_wr <= 16'd0;
        busy     <= (cfg_npix != 16'd0);
        done     <= (cfg_npix == 16'd0);
      end

      if (accept) begin
        cnt  <= cnt_inc;
        word <= word_n;
        // last must coincide exactly with the npix-th pixel
        if (s_pix_last != (cnt_inc == npix)) err_len <= 1'b1;
      end

      if ((state_n == DONE) && (state != DONE)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule
